// File: rtl/display_pkg.sv
// Display code constants and active-low seven-segment glyphs (bit 0 = a .. bit 6 = g).
package display_pkg;

    localparam logic [4:0] BLANK_CODE      = 5'h10;
    localparam logic [4:0] UNDERSCORE_CODE = 5'h1F;

    localparam logic [6:0] SEG_0 = 7'b1000000;
    localparam logic [6:0] SEG_1 = 7'b1111001;
    localparam logic [6:0] SEG_2 = 7'b0100100;
    localparam logic [6:0] SEG_3 = 7'b0110000;
    localparam logic [6:0] SEG_4 = 7'b0011001;
    localparam logic [6:0] SEG_5 = 7'b0010010;
    localparam logic [6:0] SEG_6 = 7'b0000010;
    localparam logic [6:0] SEG_7 = 7'b1111000;
    localparam logic [6:0] SEG_8 = 7'b0000000;
    localparam logic [6:0] SEG_9 = 7'b0010000;
    localparam logic [6:0] SEG_A = 7'b0001000;
    localparam logic [6:0] SEG_B = 7'b0000011;
    localparam logic [6:0] SEG_C = 7'b1000110;
    localparam logic [6:0] SEG_D = 7'b0100001;
    localparam logic [6:0] SEG_E = 7'b0000110;
    localparam logic [6:0] SEG_F = 7'b0001110;
    localparam logic [6:0] SEG_OFF        = 7'h7F;
    localparam logic [6:0] SEG_UNDERSCORE = 7'b1110111;

    typedef enum logic {
        SLOT_GUARD,
        SLOT_DRIVE
    } slot_state_e;

    // A digit lets leading-zero blanking propagate past it when it is 0 or a blank code (16..30).
    function automatic logic is_zero_or_blank(input logic [4:0] code);
        return (code == 5'd0) || (code[4] && (code != UNDERSCORE_CODE));
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational 5-bit display code to active-low segment pattern.
module seg7_decode
    import display_pkg::*;
(
    input  logic [4:0] code_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_OFF;
        if (code_i == UNDERSCORE_CODE) begin
            seg_o = SEG_UNDERSCORE;
        end else if (!code_i[4]) begin
            case (code_i[3:0])
                4'h0:    seg_o = SEG_0;
                4'h1:    seg_o = SEG_1;
                4'h2:    seg_o = SEG_2;
                4'h3:    seg_o = SEG_3;
                4'h4:    seg_o = SEG_4;
                4'h5:    seg_o = SEG_5;
                4'h6:    seg_o = SEG_6;
                4'h7:    seg_o = SEG_7;
                4'h8:    seg_o = SEG_8;
                4'h9:    seg_o = SEG_9;
                4'hA:    seg_o = SEG_A;
                4'hB:    seg_o = SEG_B;
                4'hC:    seg_o = SEG_C;
                4'hD:    seg_o = SEG_D;
                4'hE:    seg_o = SEG_E;
                default: seg_o = SEG_F;
            endcase
        end
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Four-digit multiplexed seven-segment scanner: per-frame snapshot, guard time at each
// digit switch, leading-zero blanking and saturation blink on the leftmost decimal point.
module seg7_scan_driver
    import display_pkg::*;
#(
    parameter int REFRESH_DIV  = 50000,
    parameter int GUARD        = 500,
    parameter int BLINK_FRAMES = 250
) (
    input  logic       sys_clk,
    input  logic       reset,
    input  logic [4:0] bcd3,
    input  logic [4:0] bcd2,
    input  logic [4:0] bcd1,
    input  logic [4:0] bcd0,
    input  logic       si,
    input  logic       lzb_en,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp,
    output logic       frame_start
);

    localparam int SLOT_W  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int FRAME_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [SLOT_W-1:0]  SLOT_LAST  = SLOT_W'(REFRESH_DIV - 1);
    localparam logic [SLOT_W-1:0]  GUARD_LAST = SLOT_W'(GUARD - 1);
    localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(BLINK_FRAMES - 1);

    logic [SLOT_W-1:0]  slot_cnt_q, slot_cnt_d;
    logic [1:0]         digit_idx_q;
    logic [FRAME_W-1:0] frame_cnt_q;
    logic               blink_phase_q;
    slot_state_e        state_q;
    logic [3:0][4:0]    snap_code_q;
    logic               snap_si_q;
    logic               snap_lzb_q;
    logic [3:0]         an_q, an_d;
    logic [6:0]         seg_q, seg_d;
    logic               dp_q, dp_d;

    logic               slot_wrap;
    logic               frame_end;
    logic [3:0]         lz_blank;
    logic [4:0]         cur_code;
    logic [6:0]         cur_seg;

    assign slot_wrap  = (slot_cnt_q == SLOT_LAST);
    assign frame_end  = slot_wrap && (digit_idx_q == 2'd3);
    assign slot_cnt_d = slot_wrap ? '0 : slot_cnt_q + SLOT_W'(1);

    always_comb begin
        lz_blank    = '0;
        lz_blank[3] = snap_lzb_q && (snap_code_q[3] == 5'd0);
        lz_blank[2] = snap_lzb_q && (snap_code_q[2] == 5'd0)
                      && is_zero_or_blank(snap_code_q[3]);
        lz_blank[1] = snap_lzb_q && (snap_code_q[1] == 5'd0)
                      && is_zero_or_blank(snap_code_q[3])
                      && is_zero_or_blank(snap_code_q[2]);
        cur_code    = lz_blank[digit_idx_q] ? BLANK_CODE : snap_code_q[digit_idx_q];
    end

    seg7_decode u_decode (
        .code_i (cur_code),
        .seg_o  (cur_seg)
    );

    always_comb begin
        an_d  = '1;
        seg_d = SEG_OFF;
        dp_d  = 1'b1;
        if (state_q == SLOT_DRIVE) begin
            an_d  = ~(4'b0001 << digit_idx_q);
            seg_d = cur_seg;
            dp_d  = ~((digit_idx_q == 2'd3) && snap_si_q && blink_phase_q);
        end
    end

    // state_q always matches slot_cnt_q, so the registered outputs lag the counters by one cycle.
    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            slot_cnt_q    <= '0;
            digit_idx_q   <= '0;
            frame_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
            state_q       <= SLOT_GUARD;
            snap_code_q   <= {4{BLANK_CODE}};
            snap_si_q     <= 1'b0;
            snap_lzb_q    <= 1'b0;
            an_q          <= '1;
            seg_q         <= SEG_OFF;
            dp_q          <= 1'b1;
        end else begin
            slot_cnt_q <= slot_cnt_d;
            if (slot_wrap) begin
                digit_idx_q <= digit_idx_q + 2'd1;
            end

            case (state_q)
                SLOT_GUARD: if (slot_cnt_q == GUARD_LAST) state_q <= SLOT_DRIVE;
                SLOT_DRIVE: if (slot_wrap) state_q <= SLOT_GUARD;
                default:    state_q <= SLOT_GUARD;
            endcase

            if (frame_end) begin
                snap_code_q <= {bcd3, bcd2, bcd1, bcd0};
                snap_si_q   <= si;
                snap_lzb_q  <= lzb_en;
                if (frame_cnt_q == FRAME_LAST) begin
                    frame_cnt_q   <= '0;
                    blink_phase_q <= ~blink_phase_q;
                end else begin
                    frame_cnt_q <= frame_cnt_q + FRAME_W'(1);
                end
            end

            an_q  <= an_d;
            seg_q <= seg_d;
            dp_q  <= dp_d;
        end
    end

    assign an          = an_q;
    assign seg         = seg_q;
    assign dp          = dp_q;
    assign frame_start = frame_end;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver: cycle-count reference model plus vector table.
module tb_seg7_scan_driver;

    localparam int RD    = 8;
    localparam int GD    = 2;
    localparam int BF    = 2;
    localparam int FRAME = 4 * RD;
    localparam int NV    = 11;

    logic       sys_clk = 1'b0;
    logic       reset   = 1'b1;
    logic [4:0] bcd3 = '0, bcd2 = '0, bcd1 = '0, bcd0 = '0;
    logic       si = 1'b0, lzb_en = 1'b0;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp, frame_start;

    int checks   = 0;
    int failures = 0;

    // Reference model state: edges since reset release and the loaded snapshot.
    int         m;
    logic [4:0] mcode [4];
    logic       msi, mlzb;
    logic [6:0] glyph_tab [16];

    typedef struct {
        logic [3:0][4:0] c;
        logic            lzb;
        logic [3:0][6:0] e;
    } vec_t;
    vec_t vecs [NV];

    always #5 sys_clk = ~sys_clk;

    seg7_scan_driver #(
        .REFRESH_DIV  (RD),
        .GUARD        (GD),
        .BLINK_FRAMES (BF)
    ) dut (
        .sys_clk     (sys_clk),
        .reset       (reset),
        .bcd3        (bcd3),
        .bcd2        (bcd2),
        .bcd1        (bcd1),
        .bcd0        (bcd0),
        .si          (si),
        .lzb_en      (lzb_en),
        .an          (an),
        .seg         (seg),
        .dp          (dp),
        .frame_start (frame_start)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [6:0] glyph(input logic [4:0] code);
        if (code < 5'd16) return glyph_tab[code[3:0]];
        if (code == 5'd31) return 7'b1110111;
        return 7'h7F;
    endfunction

    // Code actually shown on digit d after leading-zero blanking of the model snapshot.
    function automatic logic [4:0] shown(input int d);
        logic lead;
        lead = 1'b1;
        for (int i = 3; i >= 1; i--) begin
            if (i == d) return (mlzb && lead && mcode[i] == 5'd0) ? 5'h10 : mcode[i];
            lead = lead && (mcode[i] == 5'd0 || (mcode[i] >= 5'd16 && mcode[i] <= 5'd30));
        end
        return mcode[0];
    endfunction

    task automatic model_reset();
        m = 0;
        for (int i = 0; i < 4; i++) mcode[i] = 5'h10;
        msi  = 1'b0;
        mlzb = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge sys_clk);
        reset = 1'b0;
        model_reset();
    endtask

    task automatic step();
        int pos, slot, d, phase;
        logic [3:0] ea;
        logic [6:0] es;
        logic       edp;
        pos   = m % FRAME;
        slot  = pos % RD;
        d     = pos / RD;
        phase = (m / FRAME / BF) % 2;
        ea  = 4'hF;
        es  = 7'h7F;
        edp = 1'b1;
        if (slot >= GD) begin
            ea  = 4'hF ^ (4'b0001 << d);
            es  = glyph(shown(d));
            edp = !(d == 3 && msi && phase == 1);
        end
        if (pos == FRAME - 1) begin
            mcode[3] = bcd3; mcode[2] = bcd2; mcode[1] = bcd1; mcode[0] = bcd0;
            msi  = si;
            mlzb = lzb_en;
        end
        m++;
        @(posedge sys_clk);
        @(negedge sys_clk);
        check("model an/seg/dp", 32'({an, seg, dp}), 32'({ea, es, edp}));
        check("model frame_start", 32'(frame_start), 32'((m % FRAME) == FRAME - 1));
    endtask

    task automatic sync_frame();
        for (int i = 0; i < 2 * FRAME && frame_start !== 1'b1; i++) step();
        check("frame_start sync", 32'(frame_start), 32'd1);
    endtask

    // From a frame_start cycle: run one frame, grabbing each digit mid-DRIVE.
    task automatic capture_frame(input int chg_k, input logic [19:0] chg_codes,
                                 output logic [3:0][6:0] s, output logic [3:0][3:0] a);
        s = '1;
        a = '1;
        for (int k = 1; k <= FRAME; k++) begin
            if (k == chg_k) {bcd3, bcd2, bcd1, bcd0} = chg_codes;
            step();
            for (int d = 0; d < 4; d++) begin
                if (k == d * RD + GD + 4) begin
                    s[d] = seg;
                    a[d] = an;
                end
            end
        end
    endtask

    initial begin
        logic [3:0][6:0] s;
        logic [3:0][3:0] a;
        int cnt [8];
        int exp_cnt [8];

        glyph_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
        vecs[0]  = '{{5'd1, 5'd2, 5'd3, 5'd4},    1'b0, {7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001}};
        vecs[1]  = '{{5'd0, 5'd0, 5'd4, 5'd0},    1'b1, {7'h7F, 7'h7F, 7'b0011001, 7'b1000000}};
        vecs[2]  = '{{5'd0, 5'd0, 5'd0, 5'd0},    1'b1, {7'h7F, 7'h7F, 7'h7F, 7'b1000000}};
        vecs[3]  = '{{5'd0, 5'd2, 5'd31, 5'd5},   1'b0, {7'b1000000, 7'b0100100, 7'b1110111, 7'b0010010}};
        vecs[4]  = '{{5'd0, 5'd2, 5'd31, 5'd5},   1'b1, {7'h7F, 7'b0100100, 7'b1110111, 7'b0010010}};
        vecs[5]  = '{{5'd0, 5'd0, 5'd0, 5'd0},    1'b0, {7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000}};
        vecs[6]  = '{{5'd16, 5'd0, 5'd0, 5'd7},   1'b1, {7'h7F, 7'h7F, 7'h7F, 7'b1111000}};
        vecs[7]  = '{{5'd31, 5'd0, 5'd0, 5'd0},   1'b1, {7'b1110111, 7'b1000000, 7'b1000000, 7'b1000000}};
        vecs[8]  = '{{5'd10, 5'd11, 5'd12, 5'd13}, 1'b0, {7'b0001000, 7'b0000011, 7'b1000110, 7'b0100001}};
        vecs[9]  = '{{5'd14, 5'd15, 5'd0, 5'd9},  1'b1, {7'b0000110, 7'b0001110, 7'b1000000, 7'b0010000}};
        vecs[10] = '{{5'd0, 5'd20, 5'd0, 5'd8},   1'b1, {7'h7F, 7'h7F, 7'h7F, 7'b0000000}};
        exp_cnt = '{0, 0, 6, 6, 0, 0, 6, 6};

        // Reset release and first (blank) frame
        do_reset();
        check("reset an", 32'(an), 32'hF);
        check("reset seg", 32'(seg), 32'h7F);
        check("reset dp", 32'(dp), 32'd1);
        check("reset frame_start", 32'(frame_start), 32'd0);
        for (int k = 1; k <= FRAME; k++) begin
            step();
            case (k)
                1, 2: check("guard an", 32'(an), 32'hF);
                3: begin
                    check("walk an d0", 32'(an), 32'hE);
                    check("blank seg d0", 32'(seg), 32'h7F);
                end
                11: check("walk an d1", 32'(an), 32'hD);
                19: check("walk an d2", 32'(an), 32'hB);
                27: check("walk an d3", 32'(an), 32'h7);
                30: check("frame_start early", 32'(frame_start), 32'd0);
                31: check("frame_start at 31", 32'(frame_start), 32'd1);
                default: ;
            endcase
        end

        // Decode and blanking table
        for (int v = 0; v < NV; v++) begin
            {bcd3, bcd2, bcd1, bcd0} = vecs[v].c;
            lzb_en = vecs[v].lzb;
            si = 1'b0;
            sync_frame();
            capture_frame(0, '0, s, a);
            for (int d = 0; d < 4; d++) begin
                check($sformatf("vec%0d seg d%0d", v, d), 32'(s[d]), 32'(vecs[v].e[d]));
                check($sformatf("vec%0d an d%0d", v, d), 32'(a[d]), 32'(4'hF ^ (4'b0001 << d)));
            end
        end

        // Mid-frame input change stays out of the current frame
        {bcd3, bcd2, bcd1, bcd0} = {5'd1, 5'd2, 5'd3, 5'd4};
        lzb_en = 1'b0;
        sync_frame();
        capture_frame(10, {5'd9, 5'd9, 5'd9, 5'd9}, s, a);
        check("midframe d0", 32'(s[0]), 32'b0011001);
        check("midframe d1", 32'(s[1]), 32'b0110000);
        check("midframe d3", 32'(s[3]), 32'b1111001);
        sync_frame();
        capture_frame(0, '0, s, a);
        check("next frame d0", 32'(s[0]), 32'b0010000);
        check("next frame d3", 32'(s[3]), 32'b0010000);

        // Saturation blink: two frames off, two frames on
        do_reset();
        si = 1'b1;
        {bcd3, bcd2, bcd1, bcd0} = {5'd1, 5'd0, 5'd0, 5'd0};
        for (int i = 0; i < 8; i++) cnt[i] = 0;
        for (int k = 1; k <= 8 * FRAME; k++) begin
            step();
            if (dp === 1'b0) cnt[(k - 1) / FRAME]++;
        end
        for (int i = 0; i < 8; i++) check($sformatf("blink frame%0d dp-low cycles", i + 1), 32'(cnt[i]), 32'(exp_cnt[i]));
        si = 1'b0;

        // Asynchronous reset in the middle of a frame
        do_reset();
        {bcd3, bcd2, bcd1, bcd0} = {5'd8, 5'd8, 5'd8, 5'd8};
        for (int k = 1; k <= FRAME + 13; k++) step();
        check("pre-reset an", 32'(an), 32'hD);
        check("pre-reset seg", 32'(seg), 32'h00);
        #1 reset = 1'b1;
        #1;
        check("async reset an", 32'(an), 32'hF);
        check("async reset seg", 32'(seg), 32'h7F);
        check("async reset dp", 32'(dp), 32'd1);
        check("async reset frame_start", 32'(frame_start), 32'd0);
        do_reset();
        for (int k = 1; k <= FRAME + 3; k++) begin
            step();
            if (k == 3) begin
                check("restart an d0", 32'(an), 32'hE);
                check("restart blank seg", 32'(seg), 32'h7F);
            end
            if (k == FRAME + 3) begin
                check("live an d0", 32'(an), 32'hE);
                check("live seg d0", 32'(seg), 32'h00);
            end
        end

        // Randomized traffic against the reference model
        do_reset();
        for (int k = 0; k < 800; k++) begin
            if ($urandom_range(0, 3) == 0) begin
                bcd3   = ($urandom_range(0, 2) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
                bcd2   = ($urandom_range(0, 2) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
                bcd1   = ($urandom_range(0, 2) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
                bcd0   = 5'($urandom_range(0, 31));
                si     = 1'($urandom_range(0, 1));
                lzb_en = 1'($urandom_range(0, 1));
            end
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        failures++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
Downstream consumer of the tracker's four 5-bit display codes (bcd3..bcd0) and saturation flag si. It drives a 4-digit, common-anode, time-multiplexed seven-segment display on the board. It takes a tear-free snapshot of the codes once per scan frame, inserts anti-ghosting guard time at every digit switch, and optionally blanks leading zeros. While si is set, it blinks the leftmost decimal point to flag step-count saturation.

Parameters:
REFRESH_DIV, 50000, sys_clk cycles per digit slot (100 MHz gives 2 kHz slot rate, 500 Hz frame rate)
GUARD, 500, cycles at the start of each slot with all anodes off; must satisfy 1 <= GUARD < REFRESH_DIV
BLINK_FRAMES, 250, frames per blink half-period (about 1 Hz blink at defaults)

Ports:
sys_clk  in  1  system clock; single clock domain
reset  in  1  asynchronous, active-high reset
bcd3  in  5  display code, leftmost digit
bcd2  in  5  display code
bcd1  in  5  display code
bcd0  in  5  display code, rightmost digit
si  in  1  saturation indicator; blinks the dp of digit 3
lzb_en  in  1  leading-zero blanking enable, sampled with the snapshot
an  out  4  anodes, active-low; an[i] selects digit i
seg  out  7  segments a..g, active-low; seg[0]=a, seg[6]=g
dp  out  1  decimal point, active-low
frame_start  out  1  one-cycle pulse on the cycle the snapshot is loaded

Behaviour:
- Clock and reset: one clock (sys_clk). reset is asynchronous and active-high.
- Values on reset:
  - an=4'b1111, seg=7'h7F, dp=1, frame_start=0.
  - slot_cnt=0, digit_idx=0, frame_cnt=0, blink_phase=0.
  - Snapshot digits = BLANK (5'h10), snapshot si=0, snapshot lzb_en=0.
- slot_cnt counts 0..REFRESH_DIV-1 and wraps.
  - On wrap, digit_idx advances 0->1->2->3->0.
  - Scan order is digit 0 first.
- Per-slot two-state FSM:
  - GUARD while slot_cnt < GUARD: an=1111, seg=7'h7F, dp=1.
  - DRIVE while slot_cnt >= GUARD: an has only bit digit_idx low; seg and dp come from the decoded snapshot digit.
- Snapshot load:
  - Happens on the clock edge where slot_cnt==REFRESH_DIV-1 and digit_idx==3, i.e. the last cycle of a frame.
  - frame_start=1 in exactly that cycle.
  - Loads bcd3..0, si and lzb_en together. Inputs changing mid-frame never alter the current frame.
- After reset, the first frame displays the reset snapshot (all blank). Live data appears from frame 2.
- Output latency: an, seg and dp are registered. They reflect the counter and snapshot state of the previous cycle (1-cycle lag).
- Code decode (5-bit):
  - 0..15: hex glyphs 0-9, A-F.
  - 16..30: blank.
  - 31 (5'h1F): underscore, segment d only (seg=7'b1110111).
- Leading-zero blanking, applied to the snapshot when snapshot lzb_en=1:
  - Digit 3 blanks if its code is 0.
  - Digit 2 blanks if its code is 0 and digit 3 is 0 or blank.
  - Digit 1 blanks if its code is 0 and digits 3 and 2 are both 0 or blank.
  - Digit 0 is never blanked. Codes 31 and 1..15 stop the blanking chain.
- Blink:
  - frame_cnt increments on every frame_start and counts 0..BLINK_FRAMES-1.
  - At the wrap, blink_phase toggles.
  - dp=0 only during the DRIVE state of digit 3 when snapshot si=1 and blink_phase=1. Otherwise dp=1.
- Reset mid-frame: all counters and outputs return to their reset values immediately (asynchronously). The next frame starts at digit 0, slot_cnt 0.
- Counter widths: $clog2 of the respective parameter, minimum 1 bit. No overflow is possible.

Decomposition:
- Package display_pkg:
  - Code constants BLANK_CODE=5'h10 and UNDERSCORE_CODE=5'h1F.
  - A 7-bit active-low segment constant for each glyph 0-F, plus SEG_OFF and SEG_UNDERSCORE.
- Sub-module seg7_decode: combinational, 5-bit code in, 7-bit active-low seg out. It is instantiated once, on the muxed snapshot digit.

Test Plan:
All scenarios use REFRESH_DIV=8, GUARD=2, BLINK_FRAMES=2.
1. Reset release, then 32 cycles:
   - an=1111 and seg=7'h7F throughout the guard cycles.
   - an walks 1110, 1101, 1011, 0111 during the DRIVE cycles with seg=7'h7F (blank snapshot).
   - frame_start pulses at cycle 31.
2. bcd3..0 = 1,2,3,4 applied before the first frame_start:
   - In frame 2, the digit 0 DRIVE shows seg=7'b0011001 ("4").
   - The digit 3 DRIVE shows seg=7'b1111001 ("1").
   - Changing the inputs mid-frame 2 has no effect until frame 3.
3. lzb_en=1 with codes 0,0,4,0:
   - Digits 3 and 2 show blank, digit 1 shows "4", digit 0 shows "0" (seg=7'b1000000).
   - With codes 0,0,0,0, only digit 0 is lit with "0".
4. Distance format with codes 0,2,31,5:
   - Digit 1 shows seg=7'b1110111 (underscore).
   - Digit 2 shows "2" and digit 0 shows "5".
   - With lzb_en=1, digit 3 is blank.
5. si=1 held:
   - dp=0 only in the digit 3 DRIVE cycles of frames where blink_phase=1.
   - blink_phase toggles every 2 frames, so the pattern is 2 frames off, then 2 frames on.
   - dp=1 in all other cycles.
6. reset asserted at cycle 13 of a frame: an=1111 and seg=7'h7F in the same cycle. After release, scanning restarts at digit 0 and the display is blank for one frame.
